// File: rtl/alu_mdu.sv
// alu_mdu: clocked ALU with registered flags and an iterative shift-add multiplier / restoring divider.
// The divider is built only when ALU_DIV_EN is defined; otherwise DIVU/DIV decode as illegal codes.
module alu_mdu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] t,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             div_zero,
  output logic             illegal
);
  localparam int unsigned W2 = 2 * WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
`ifdef ALU_DIV_EN
  localparam logic [1:0] DIV  = 2'd2;
`endif
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] OP_AND   = 4'h0;
  localparam logic [3:0] OP_OR    = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_SLT   = 4'h7;
  localparam logic [3:0] OP_MULTU = 4'h8;
  localparam logic [3:0] OP_MULT  = 4'h9;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'hA;
  localparam logic [3:0] OP_DIV   = 4'hB;
`endif
  localparam logic [3:0] OP_NOR   = 4'hC;
  localparam logic [3:0] OP_SLTU  = 4'hD;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] acc_hi, acc_hi_nxt, acc_lo, acc_lo_nxt, opb, opb_nxt;
  logic             neg_lo, neg_lo_nxt;
  logic [WIDTH-1:0] result_nxt, hi_nxt;
  logic             cout_nxt, overflow_nxt, zero_nxt, div_zero_nxt, illegal_nxt;

  // Single-cycle ALU
  logic [WIDTH:0]   add_sum, sub_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout, alu_ovf, alu_ill;

  assign add_sum = {1'b0, s} + {1'b0, t};
  assign sub_sum = {1'b0, s} + {1'b0, ~t} + (WIDTH+1)'(1);

  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    alu_ill  = 1'b0;
    case (control)
      OP_AND:  alu_res = s & t;
      OP_OR:   alu_res = s | t;
      OP_NOR:  alu_res = ~(s | t);
      OP_ADD: begin
        alu_res  = add_sum[WIDTH-1:0];
        alu_cout = add_sum[WIDTH];
        alu_ovf  = (s[WIDTH-1] == t[WIDTH-1]) && (add_sum[WIDTH-1] != s[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res  = sub_sum[WIDTH-1:0];
        alu_cout = sub_sum[WIDTH];
        alu_ovf  = (s[WIDTH-1] != t[WIDTH-1]) && (sub_sum[WIDTH-1] != s[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(s) < $signed(t))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (s < t)};
      default: alu_ill = 1'b1;
    endcase
  end

  // Signed MULT/DIV have odd codes; iterate on magnitudes and fix signs at the end
  logic             sgn_op;
  logic [WIDTH-1:0] mag_s, mag_t;
  assign sgn_op = control[0];
  assign mag_s  = (sgn_op && s[WIDTH-1]) ? (~s + WIDTH'(1)) : s;
  assign mag_t  = (sgn_op && t[WIDTH-1]) ? (~t + WIDTH'(1)) : t;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [W2-1:0]    mul_prod;
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
  assign mul_hi   = mul_sum[WIDTH:1];
  assign mul_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};
  assign mul_prod = neg_lo ? (~{mul_hi, mul_lo} + W2'(1)) : {mul_hi, mul_lo};

`ifdef ALU_DIV_EN
  logic             neg_hi, neg_hi_nxt, ovf_pend, ovf_pend_nxt;
  logic [WIDTH:0]   div_sh;
  logic             div_ok;
  logic [WIDTH-1:0] div_hi, div_lo, div_q, div_r;
  // Remainder stays below the divisor, so the difference always fits WIDTH bits
  assign div_sh = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ok = div_sh >= {1'b0, opb};
  assign div_hi = div_ok ? (div_sh[WIDTH-1:0] - opb) : div_sh[WIDTH-1:0];
  assign div_lo = {acc_lo[WIDTH-2:0], div_ok};
  assign div_q  = neg_lo ? (~div_lo + WIDTH'(1)) : div_lo;
  assign div_r  = neg_hi ? (~div_hi + WIDTH'(1)) : div_hi;
`endif

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    acc_hi_nxt   = acc_hi;
    acc_lo_nxt   = acc_lo;
    opb_nxt      = opb;
    neg_lo_nxt   = neg_lo;
`ifdef ALU_DIV_EN
    neg_hi_nxt   = neg_hi;
    ovf_pend_nxt = ovf_pend;
`endif
    result_nxt   = result;
    hi_nxt       = hi;
    cout_nxt     = cout;
    overflow_nxt = overflow;
    zero_nxt     = zero;
    div_zero_nxt = div_zero;
    illegal_nxt  = illegal;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_nxt    = '0;
          acc_hi_nxt = '0;
          acc_lo_nxt = mag_s;
          opb_nxt    = mag_t;
          neg_lo_nxt = sgn_op && (s[WIDTH-1] ^ t[WIDTH-1]);
          if (control == OP_MULTU || control == OP_MULT) begin
            state_nxt = MUL;
          end
`ifdef ALU_DIV_EN
          else if (control == OP_DIVU || control == OP_DIV) begin
            neg_hi_nxt   = sgn_op && s[WIDTH-1];
            ovf_pend_nxt = sgn_op && (s == {1'b1, {(WIDTH-1){1'b0}}}) && (t == {WIDTH{1'b1}});
            if (t == '0) begin
              state_nxt    = DONE;
              result_nxt   = {WIDTH{1'b1}};
              hi_nxt       = s;
              cout_nxt     = 1'b0;
              overflow_nxt = 1'b0;
              zero_nxt     = 1'b0;
              div_zero_nxt = 1'b1;
              illegal_nxt  = 1'b0;
            end else begin
              state_nxt = DIV;
            end
          end
`endif
          else begin
            state_nxt    = DONE;
            result_nxt   = alu_res;
            hi_nxt       = '0;
            cout_nxt     = alu_cout;
            overflow_nxt = alu_ovf;
            zero_nxt     = (alu_res == '0);
            div_zero_nxt = 1'b0;
            illegal_nxt  = alu_ill;
          end
        end
      end
      MUL: begin
        acc_hi_nxt = mul_hi;
        acc_lo_nxt = mul_lo;
        cnt_nxt    = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_nxt    = DONE;
          result_nxt   = mul_prod[WIDTH-1:0];
          hi_nxt       = mul_prod[W2-1:WIDTH];
          cout_nxt     = 1'b0;
          overflow_nxt = 1'b0;
          zero_nxt     = (mul_prod[WIDTH-1:0] == '0);
          div_zero_nxt = 1'b0;
          illegal_nxt  = 1'b0;
        end
      end
`ifdef ALU_DIV_EN
      DIV: begin
        acc_hi_nxt = div_hi;
        acc_lo_nxt = div_lo;
        cnt_nxt    = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_nxt    = DONE;
          result_nxt   = div_q;
          hi_nxt       = div_r;
          cout_nxt     = 1'b0;
          overflow_nxt = ovf_pend;
          zero_nxt     = (div_q == '0);
          div_zero_nxt = 1'b0;
          illegal_nxt  = 1'b0;
        end
      end
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb      <= '0;
      neg_lo   <= 1'b0;
`ifdef ALU_DIV_EN
      neg_hi   <= 1'b0;
      ovf_pend <= 1'b0;
`endif
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      hi       <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
      div_zero <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      acc_hi   <= acc_hi_nxt;
      acc_lo   <= acc_lo_nxt;
      opb      <= opb_nxt;
      neg_lo   <= neg_lo_nxt;
`ifdef ALU_DIV_EN
      neg_hi   <= neg_hi_nxt;
      ovf_pend <= ovf_pend_nxt;
`endif
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == DONE);
      result   <= result_nxt;
      hi       <= hi_nxt;
      cout     <= cout_nxt;
      overflow <= overflow_nxt;
      zero     <= zero_nxt;
      div_zero <= div_zero_nxt;
      illegal  <= illegal_nxt;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: table vectors, randomized ops against a plain-arithmetic model, and hand sequences
// for busy-time start, reset abort and output retention. Honours ALU_DIV_EN like the design.
module tb_alu_mdu;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [3:0]  control;
  logic [31:0] s, t;
  logic        busy, done, cout, overflow, zero, div_zero, illegal;
  logic [31:0] result, hi;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a, b, r, h;
    logic        co, ov, z, dz, il;
    int          lat;
  } vec_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .control(control), .s(s), .t(t),
    .busy(busy), .done(done), .result(result), .hi(hi), .cout(cout),
    .overflow(overflow), .zero(zero), .div_zero(div_zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] r, input logic [31:0] h, input logic co,
                              input logic ov, input logic z, input logic dz, input logic il,
                              input int lat);
    vec_t v;
    v.c = c; v.a = a; v.b = b; v.r = r; v.h = h;
    v.co = co; v.ov = ov; v.z = z; v.dz = dz; v.il = il; v.lat = lat;
    return v;
  endfunction

  // Reference computed with 64-bit integer arithmetic
  function automatic vec_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    longint sa, sb, sr;
    longint unsigned ua, ub;
    logic [63:0] w;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    v = mk(c, a, b, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    case (c)
      4'h0: v.r = a & b;
      4'h1: v.r = a | b;
      4'hC: v.r = ~(a | b);
      4'h2: begin
        w = ua + ub; v.r = w[31:0]; v.co = w[32];
        sr = sa + sb; v.ov = (sr > SMAX) || (sr < SMIN);
      end
      4'h6: begin
        v.r = a - b; v.co = (ua >= ub);
        sr = sa - sb; v.ov = (sr > SMAX) || (sr < SMIN);
      end
      4'h7: v.r = (sa < sb) ? 32'd1 : 32'd0;
      4'hD: v.r = (ua < ub) ? 32'd1 : 32'd0;
      4'h8: begin w = ua * ub; v.r = w[31:0]; v.h = w[63:32]; v.lat = 33; end
      4'h9: begin w = sa * sb; v.r = w[31:0]; v.h = w[63:32]; v.lat = 33; end
`ifdef ALU_DIV_EN
      4'hA, 4'hB: begin
        if (b == 32'h0) begin
          v.r = 32'hFFFFFFFF; v.h = a; v.dz = 1'b1;
        end else if (c == 4'hA) begin
          w = ua / ub; v.r = w[31:0];
          w = ua % ub; v.h = w[31:0];
          v.lat = 33;
        end else begin
          sr = sa / sb; w = sr; v.r = w[31:0]; v.ov = (sr > SMAX);
          sr = sa % sb; w = sr; v.h = w[31:0];
          v.lat = 33;
        end
      end
`endif
      default: v.il = 1'b1;
    endcase
    v.z = (v.r == 32'h0);
    return v;
  endfunction

  // Issue one op in IDLE; returns at the negedge where done is seen (or the bound expires)
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; control = c; s = a; t = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (busy) bcnt++;
  endtask

  task automatic check_outs(input string nm, input vec_t e, input int lat, input int bcnt);
    chk({nm, ".done"},     {63'h0, done},     64'h1);
    chk({nm, ".lat"},      64'(lat),          64'(e.lat));
    chk({nm, ".busy"},     64'(bcnt),         64'(e.lat));
    chk({nm, ".result"},   {32'h0, result},   {32'h0, e.r});
    chk({nm, ".hi"},       {32'h0, hi},       {32'h0, e.h});
    chk({nm, ".flags"},    {59'h0, cout, overflow, zero, div_zero, illegal},
                           {59'h0, e.co, e.ov, e.z, e.dz, e.il});
  endtask

  vec_t        tbl[$];
  vec_t        e;
  logic [31:0] specials[5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
  logic [31:0] ra, rb;
  logic [3:0]  rc;
  int          lat, bcnt, dones;

  initial begin
    rst_n = 1'b0; start = 1'b0; control = 4'h0; s = 32'h0; t = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst.busy",   {63'h0, busy},  64'h0);
    chk("rst.done",   {63'h0, done},  64'h0);
    chk("rst.result", {32'h0, result}, 64'h0);
    chk("rst.flags",  {59'h0, cout, overflow, zero, div_zero, illegal}, 64'h04);
    rst_n = 1'b1;

    //            c      s             t             result        hi            co ov z  dz il lat
    tbl.push_back(mk(4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h00000000, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(4'h6, 32'h00000005, 32'h00000005, 32'h00000000, 32'h00000000, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(4'h7, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h00000000, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'hD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(4'h9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 33));
    tbl.push_back(mk(4'hF, 32'h00001234, 32'h00005678, 32'h00000000, 32'h00000000, 0, 0, 1, 0, 1, 1));
    tbl.push_back(mk(4'h2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(4'h6, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 32'h00000000, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'h6, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h00000000, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h00000000, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'h1, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'h00000000, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'hC, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'h8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 0, 0, 0, 0, 0, 33));
    tbl.push_back(mk(4'h9, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 0, 0, 1, 0, 0, 33));
`ifdef ALU_DIV_EN
    tbl.push_back(mk(4'hB, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 33));
    tbl.push_back(mk(4'hA, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 32'h00001234, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(4'hB, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 0, 1, 0, 0, 0, 33));
    tbl.push_back(mk(4'hA, 32'h00000100, 32'h00000007, 32'h00000024, 32'h00000004, 0, 0, 0, 0, 0, 33));
    tbl.push_back(mk(4'hB, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 0, 0, 0, 0, 0, 33));
`else
    tbl.push_back(mk(4'hA, 32'h00000005, 32'h00000003, 32'h00000000, 32'h00000000, 0, 0, 1, 0, 1, 1));
    tbl.push_back(mk(4'hB, 32'h00000005, 32'h00000003, 32'h00000000, 32'h00000000, 0, 0, 1, 0, 1, 1));
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      run_op(tbl[i].c, tbl[i].a, tbl[i].b, lat, bcnt);
      check_outs($sformatf("vec%0d", i), tbl[i], lat, bcnt);
    end

    for (int i = 0; i < 60; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = specials[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) rb = specials[$urandom_range(0, 4)];
      e = model(rc, ra, rb);
      run_op(rc, ra, rb, lat, bcnt);
      check_outs($sformatf("rnd%0d_c%h", i, rc), e, lat, bcnt);
    end

    // MULT with start pulsed while busy: must be ignored, and no op queued
    @(negedge clk);
    start = 1'b1; control = 4'h9; s = 32'hFFFFFFFE; t = 32'h3;
    @(negedge clk);
    start = 1'b0; lat = 1; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (lat == 5) begin start = 1'b1; control = 4'h2; s = 32'h1; t = 32'h1; end
      if (lat == 7) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy) bcnt++;
    e = mk(4'h9, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFA, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 33);
    check_outs("busy_start", e, lat, bcnt);
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("busy_start.noqueue", 64'(dones), 64'h0);
    chk("hold.result", {32'h0, result}, 64'hFFFFFFFA);
    chk("hold.hi",     {32'h0, hi},     64'hFFFFFFFF);

    // Reset in the middle of a MULTU aborts it without a done pulse
    @(negedge clk);
    start = 1'b1; control = 4'h8; s = 32'h12345678; t = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort.busy_before", {63'h0, busy}, 64'h1);
    rst_n = 1'b0;
    #1;
    chk("abort.busy",   {63'h0, busy},   64'h0);
    chk("abort.done",   {63'h0, done},   64'h0);
    chk("abort.result", {32'h0, result}, 64'h0);
    chk("abort.zero",   {63'h0, zero},   64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort.nodone", 64'(dones), 64'h0);

    e = model(4'hF, 32'hDEADBEEF, 32'h1);
    run_op(4'hF, 32'hDEADBEEF, 32'h1, lat, bcnt);
    check_outs("illegal_after_abort", e, lat, bcnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
